lcd_driver: RTL

Converts LCD words written by software into HD44780-compliant bus cycles. It sits directly downstream of the memory-mapped output buffer and consumes the LCD register value plus a one-cycle write strobe. For each accepted word it generates setup, enable-pulse, hold and execution-wait timing. A one-deep pending slot absorbs back-to-back writes, and a status word is returned for the input buffer so software can poll busy and overflow.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD bus sequencer.
// Bit positions refer to the software-visible LCD register word.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_t;

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    localparam int ST_BUSY = 0;
    localparam int ST_PEND = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_W    = 3;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    localparam logic [7:0] CLR_OP_LO = 8'h01;
    localparam logic [7:0] CLR_OP_HI = 8'h03;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic [7:0] data;
    } lcd_cmd_t;

    function automatic logic is_clear(input lcd_cmd_t c);
        return !c.rs && (c.data >= CLR_OP_LO) && (c.data <= CLR_OP_HI);
    endfunction

endpackage

// File: rtl/lcd_driver.sv
// HD44780 bus sequencer: setup, E pulse, hold and execution wait per word.
// A one-deep pending slot absorbs writes that arrive while busy.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 3,
    parameter int T_PW    = 13,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    input  logic        i_lcd_wr,
    input  logic        i_ovf_clr,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic [31:0] o_lcd_status
);

    localparam int CNT_MAX = (T_CLR > T_EXEC) ? T_CLR : T_EXEC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    lcd_state_t      state;
    lcd_state_t      state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    lcd_cmd_t        cur;
    lcd_cmd_t        cur_n;
    lcd_cmd_t        slot;
    lcd_cmd_t        slot_n;
    lcd_cmd_t        in_cmd;
    logic            pend;
    logic            pend_n;
    logic            ovf;
    logic            ovf_n;
    logic            ovf_set;
    logic            en_q;
    logic [ST_W-1:0] status;
    logic [ST_W-1:0] status_n;
    logic            cnt_done;
    logic            eop;
    logic            free;
    logic            direct;
    logic            launch;
    logic            unused_word;

    assign in_cmd.on   = i_lcd_word[LCD_ON_BIT];
    assign in_cmd.rs   = i_lcd_word[LCD_RS_BIT];
    assign in_cmd.data = i_lcd_word[7:0];
    assign unused_word = ^{i_lcd_word[30:10], i_lcd_word[LCD_RW_BIT]};

    // The slot drains at the end of EXEC, or from IDLE if it filled then.
    assign cnt_done = (cnt == '0);
    assign eop      = (state == IDLE) || ((state == EXEC) && cnt_done);
    assign free     = pend && eop;
    assign direct   = i_lcd_wr && (state == IDLE) && !pend;
    assign launch   = free || direct;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (launch) begin
                    state_n = SETUP;
                    cnt_n   = CW'(T_SETUP - 1);
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    state_n = PULSE;
                    cnt_n   = CW'(T_PW - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_done) begin
                    state_n = HOLD;
                    cnt_n   = CW'(T_HOLD - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    state_n = EXEC;
                    cnt_n   = is_clear(cur) ? CW'(T_CLR - 1)
                                            : CW'(T_EXEC - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            EXEC: begin
                if (cnt_done) begin
                    if (launch) begin
                        state_n = SETUP;
                        cnt_n   = CW'(T_SETUP - 1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        cur_n   = cur;
        slot_n  = slot;
        pend_n  = pend;
        ovf_set = 1'b0;
        if (free) begin
            cur_n  = slot;
            pend_n = 1'b0;
        end else if (direct) begin
            cur_n = in_cmd;
        end
        // A write in the cycle the slot drains refills it instead of dropping.
        if (i_lcd_wr && !direct) begin
            if (!pend || free) begin
                slot_n = in_cmd;
                pend_n = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        ovf_n = ovf;
        if (ovf_set) begin
            ovf_n = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_n = 1'b0;
        end
        status_n          = '0;
        status_n[ST_BUSY] = (state_n != IDLE) || pend_n;
        status_n[ST_PEND] = pend_n;
        status_n[ST_OVF]  = ovf_n;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            cur    <= '0;
            slot   <= '0;
            pend   <= 1'b0;
            ovf    <= 1'b0;
            en_q   <= 1'b0;
            status <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cur    <= cur_n;
            slot   <= slot_n;
            pend   <= pend_n;
            ovf    <= ovf_n;
            en_q   <= (state_n == PULSE);
            status <= status_n;
        end
    end

    assign o_lcd_on     = cur.on;
    assign o_lcd_en     = en_q;
    assign o_lcd_rs     = cur.rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_data   = cur.data;
    assign o_lcd_status = {{(32 - ST_W){1'b0}}, status};

endmodule
